// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle sequencer: state encoding,
// decoded-op bit positions and op classification helpers.
package mc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  localparam int OP_W   = 31;
  localparam int OP_LW  = 24;
  localparam int OP_SW  = 25;
  localparam int OP_BNE = 26;
  localparam int OP_BEQ = 27;
  localparam int OP_J   = 28;
  localparam int OP_JAL = 29;
  localparam int OP_JR  = 30;

  // Branches and jumps finish in EXEC; they never touch memory or WB.
  function automatic logic is_ctrl(input logic [OP_W-1:0] op);
    return op[OP_BNE] | op[OP_BEQ] | op[OP_J] | op[OP_JAL] | op[OP_JR];
  endfunction

  function automatic logic is_mem(input logic [OP_W-1:0] op);
    return op[OP_LW] | op[OP_SW];
  endfunction

endpackage

// File: rtl/mc_if.sv
// Bundle of sequencer control, memory handshake and status signals.
interface mc_if #(parameter int CNT_W = 32) ();

  logic                    run;
  logic [mc_pkg::OP_W-1:0] op;
  logic                    zero;
  logic                    im_ack;
  logic                    dm_ack;
  logic                    im_req;
  logic                    ir_we;
  logic                    pc_we;
  logic                    rf_w;
  logic                    dm_req;
  logic                    dm_w;
  logic                    dm_r;
  logic                    retired;
  logic [CNT_W-1:0]        retire_cnt;
  logic                    illegal;
  mc_pkg::state_t          state;

  modport master (
    input  run, op, zero, im_ack, dm_ack,
    output im_req, ir_we, pc_we, rf_w, dm_req, dm_w, dm_r,
           retired, retire_cnt, illegal, state
  );

  modport slave (
    output run, op, zero, im_ack, dm_ack,
    input  im_req, ir_we, pc_we, rf_w, dm_req, dm_w, dm_r,
           retired, retire_cnt, illegal, state
  );

endinterface

// File: rtl/mc_retire_cnt.sv
// Retired-instruction counter; wraps modulo 2^CNT_W.
module mc_retire_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the state-dependent datapath enables.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  mc_if.master  bus
);

  state_t state_reg;
  state_t state_next;
  logic   im_req_reg;
  logic   pc_we_reg;
  logic   rf_w_reg;
  logic   dm_req_reg;
  logic   dm_w_reg;
  logic   dm_r_reg;
  logic   illegal_reg;
  logic   retire;
  logic   op_onehot;

  logic [OP_W-1:0] multi_bit;

  // A bit flags "multiple hot" when it is set alongside any other bit.
  genvar gi;
  generate
    for (gi = 0; gi < OP_W; gi++) begin : g_onehot
      localparam logic [OP_W-1:0] OTHERS = ~(OP_W'(1) << gi);
      assign multi_bit[gi] = bus.op[gi] & (|(bus.op & OTHERS));
    end
  endgenerate

  assign op_onehot = (|bus.op) & ~(|multi_bit);

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    unique case (state_reg)
      IDLE:   if (bus.run) state_next = FETCH;
      FETCH:  if (bus.im_ack) state_next = DECODE;
      DECODE: state_next = op_onehot ? EXEC : TRAP;
      EXEC: begin
        if (is_mem(bus.op)) begin
          state_next = MEM;
        end else if (is_ctrl(bus.op)) begin
          retire     = 1'b1;
          state_next = bus.run ? FETCH : IDLE;
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        if (bus.dm_ack) begin
          if (dm_w_reg) begin
            retire     = 1'b1;
            state_next = bus.run ? FETCH : IDLE;
          end else begin
            state_next = WB;
          end
        end
      end
      WB: begin
        retire     = 1'b1;
        state_next = bus.run ? FETCH : IDLE;
      end
      TRAP:    state_next = TRAP;
      default: state_next = IDLE;
    endcase
  end

  // Moore strobes are decoded from the next state so they are glitch-free
  // registers that line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      im_req_reg  <= 1'b0;
      pc_we_reg   <= 1'b0;
      rf_w_reg    <= 1'b0;
      dm_req_reg  <= 1'b0;
      dm_w_reg    <= 1'b0;
      dm_r_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      im_req_reg  <= (state_next == FETCH);
      pc_we_reg   <= (state_next == EXEC);
      rf_w_reg    <= (state_next == WB) ||
                     ((state_next == EXEC) && bus.op[OP_JAL]);
      dm_req_reg  <= (state_next == MEM);
      illegal_reg <= (state_next == TRAP);
      // Direction is captured on MEM entry and frozen until MEM is left.
      if (state_next == MEM) begin
        if (state_reg != MEM) begin
          dm_w_reg <= bus.op[OP_SW];
          dm_r_reg <= bus.op[OP_LW];
        end
      end else begin
        dm_w_reg <= 1'b0;
        dm_r_reg <= 1'b0;
      end
    end
  end

  mc_retire_cnt #(.CNT_W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .cnt   (bus.retire_cnt)
  );

  assign bus.state   = state_reg;
  assign bus.im_req  = im_req_reg;
  assign bus.ir_we   = (state_reg == FETCH) & bus.im_ack;
  assign bus.pc_we   = pc_we_reg;
  assign bus.rf_w    = rf_w_reg;
  assign bus.dm_req  = dm_req_reg;
  assign bus.dm_w    = dm_w_reg;
  assign bus.dm_r    = dm_r_reg;
  assign bus.retired = retire;
  assign bus.illegal = illegal_reg;

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle sequencer for the MIPS-31 datapath: replaces the free-running PC/RF/DM clock gating with a state machine that steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It runs memory handshakes with instruction and data memory, raises write enables only in the proper state, and counts retired instructions. It sits beside the combinational decoder, which still drives the mux selects m[8:0] and ALUC. It takes the decoder's one-hot op vector and drives every state-dependent enable.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  permits starting a new instruction
- op  in  31  one-hot decoded instruction; bit indices: 24 lw, 25 sw, 26 bne, 27 beq, 28 j, 29 jal, 30 jr, all others ALU class
- zero  in  1  ALU zero flag, valid in EXEC
- im_ack  in  1  instruction memory has data for im_req
- dm_ack  in  1  data memory finished access for dm_req
- im_req  out  1  instruction fetch request
- ir_we  out  1  instruction register load strobe
- pc_we  out  1  PC update strobe
- rf_w  out  1  register file write enable
- dm_req  out  1  data memory chip select / request
- dm_w  out  1  data memory write
- dm_r  out  1  data memory read
- retired  out  1  one-cycle pulse per completed instruction
- retire_cnt  out  CNT_W  retired-instruction count
- illegal  out  1  sticky trap flag
- state  out  3  current state, for debug

## Operation
- States:
  - IDLE: all strobes 0.
  - FETCH: im_req=1.
  - DECODE: no outputs.
  - EXEC: pc_we=1.
  - MEM: dm_req=1, dm_w=op[25], dm_r=op[24].
  - WB: rf_w=1.
  - TRAP: illegal=1.
- IDLE -> FETCH when run=1.
- FETCH stays until im_ack. ir_we = FETCH & im_ack (Mealy). Then -> DECODE.
- DECODE: if op is zero or not one-hot -> TRAP; else -> EXEC.
- EXEC: pc_we pulses for every instruction. The decoder's m[1] selects PC+4 or the target, so a branch not taken still writes PC+4.
  - jal also asserts rf_w in EXEC.
  - lw/sw -> MEM.
  - bne, beq, j, jal, jr retire -> FETCH.
  - All others -> WB.
- MEM stays until dm_ack. On ack: sw retires -> FETCH; lw -> WB.
- WB: retire -> FETCH.
- On retire, if run=0 the next state is IDLE instead of FETCH.
- TRAP is absorbing; only rst_n exits it. illegal=1 in TRAP.
- retire_cnt increments by 1 on every retired pulse and wraps modulo 2^CNT_W.

## Timing
- Reset (async, rst_n=0): state=IDLE, retire_cnt=0, every output 0. After release, the first transition happens at the first rising edge.
- Acks are sampled at the rising edge while the request is high. A same-cycle ack means zero wait states. An ack while the request is low is ignored.
- Cycle counts with zero-wait memory: ALU 4, lw 5, sw 4, branch/jump 3. Each memory wait cycle adds 1.
- retired is asserted combinationally in the retiring state's final cycle. The counter updates at that edge.
- An ack and run falling in the same cycle: the instruction completes and the sequencer goes to IDLE.
- dm_w and dm_r are held stable for the whole of MEM. im_req/dm_req never drop before their ack.
- rst_n asserted mid-instruction aborts it immediately. No partial retire is counted.

## Structure
- Shared package mc_pkg:
  - state enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP
  - op bit index constants: OP_LW=24, OP_SW=25, OP_BNE=26, OP_BEQ=27, OP_J=28, OP_JAL=29, OP_JR=30
- One sub-module, mc_retire_cnt: parameterised CNT_W counter with increment enable and async reset.

## Test plan
- Reset, then run=1, ALU op (op[0]=1), zero-wait acks -> im_req in cycle 1, ir_we in cycle 1, pc_we in cycle 3, rf_w in cycle 4; retire_cnt becomes 1.
- lw (op[24]) with dm_ack delayed 3 cycles -> dm_req and dm_r held 4 cycles, dm_w=0, then rf_w for 1 cycle; 8 cycles total.
- beq with zero=1, then bne with zero=1 -> pc_we once in each EXEC, rf_w never asserted; retire_cnt advances by 2; 3 cycles each.
- op=0 in DECODE, and separately op with bits 3 and 24 set -> TRAP, illegal=1 sticky, no further im_req until rst_n.
- Preload retire_cnt near max (CNT_W=4, 15 retires) plus one more retire -> wraps to 0. run=0 at a retire -> IDLE with im_req low.
- rst_n pulsed low during MEM of an sw -> dm_req drops asynchronously, state=IDLE, retire_cnt=0.
